imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Boot sequencer for the rv32i core. Receives a program image as a byte stream (valid/ready)
//  and packs it into little-endian 32-bit words. Writes those words into instruction memory
//  through its write port, and holds the core in reset until the image is complete.
//  Replaces the simulation-only hex preload; sits between the UART RX byte interface and
//  imem, and drives the core's reset_n.
// PARAMETERS
//  IMEM_DEPTH      1024          imem size in 32-bit words
//  ADDR_W          $clog2(IMEM_DEPTH)  word-address width
//  TIMEOUT_CYCLES  100000        max idle cycles between bytes once an image has started
//  MAGIC           32'hB007_C0DE required first word of every image
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  rx_valid     in   1       byte available on rx_data
//  rx_data      in   8       incoming image byte
//  rx_ready     out  1       loader can accept a byte
//  imem_we      out  1       one-cycle imem write strobe
//  imem_addr    out  ADDR_W  imem word address
//  imem_wdata   out  32      imem write data
//  core_reset_n out  1       active-low reset to rv32i; 0 while loading
//  boot_done    out  1       image loaded; core released
//  boot_error   out  1       bad magic, oversize length or timeout; sticky until reset
// BEHAVIOUR
//  - Single clock domain (clk). Reset is synchronous and active-high.
//  - Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset_n=0,
//    boot_done=0, boot_error=0.
//  - On the first cycle after reset the FSM is in S_MAGIC and rx_ready=1.
//  - Byte handshake: a byte is accepted when rx_valid & rx_ready.
//    rx_ready=1 only in S_MAGIC, S_LEN and S_DATA.
//  - Packing: a byte counter of 0..3 places byte k at bits [8k+7:8k], little-endian.
//    The 4th accepted byte completes a word.
//  - FSM states: S_MAGIC -> S_LEN -> S_DATA -> S_DONE; any error goes to S_ERR.
//  - S_MAGIC: compare the completed word with MAGIC.
//    Match -> S_LEN. Mismatch -> S_ERR.
//  - S_LEN: the completed word is N, the number of words to load.
//    N==0 -> S_DONE. N>IMEM_DEPTH -> S_ERR. Otherwise latch N, clear the word index,
//    go to S_DATA.
//  - S_DATA: on the edge after the 4th byte of each word, for exactly one cycle:
//    imem_we=1, imem_addr=index, imem_wdata=word. The index then increments.
//    On the edge after the 4th byte of word N-1, the FSM enters S_DONE.
//    That is the same edge on which the final imem_we pulse is asserted.
//  - S_DONE and S_ERR are terminal; only reset leaves them.
//  - S_DONE: core_reset_n=1 and boot_done=1, both registered. They assert one cycle after
//    S_DONE is entered, so the core never runs before the final write has landed.
//    Further rx bytes are ignored (rx_ready=0).
//  - S_ERR: boot_error=1 from the cycle after entry. core_reset_n stays 0; rx_ready=0.
//  - Timeout: the counter clears on every accepted byte. It does not run in S_MAGIC while
//    zero bytes have been accepted; it runs in every other loading state.
//    Counter reaching TIMEOUT_CYCLES -> S_ERR.
//  - Simultaneous events: a byte accepted in the same cycle as an imem_we pulse is legal.
//    Packing is independent of the write stage, so full throughput is 1 byte/cycle.
//  - Reset mid-load: all state, the partial word and the counters are discarded and the
//    core is held in reset again. imem contents are not cleared; the next image overwrites them.
//  - Widths: the word index is ADDR_W+1 bits, so N==IMEM_DEPTH is reachable.
//    The N comparison uses the full 32 bits.
// STRUCTURE
//  - Package boot_pkg: boot_state_e {S_MAGIC, S_LEN, S_DATA, S_DONE, S_ERR},
//    BOOT_MAGIC constant, default TIMEOUT_CYCLES.
//  - One sub-module, byte_word_packer: accepts bytes, emits a 32-bit word with a
//    one-cycle word_valid pulse, and supports a synchronous clear.
//  - The FSM, index counter, timeout counter and output registers live in imem_boot_loader.
// TESTING
//  1. Bytes DE C0 07 B0, 02 00 00 00, 13 00 00 00, 93 00 10 00 ->
//     imem_we pulses at addr 0 (32'h00000013) and addr 1 (32'h00100093);
//     boot_done=1 and core_reset_n=1 exactly one cycle after the second pulse.
//  2. Bad magic (bytes EF BE AD DE) -> boot_error=1, core_reset_n stays 0, no imem_we, rx_ready=0.
//  3. Magic, then N=32'h0000_0401 with IMEM_DEPTH=1024 -> S_ERR, no writes.
//     Magic, then N=0 -> boot_done=1 with zero writes.
//  4. Magic, N=1, then only 2 data bytes followed by TIMEOUT_CYCLES idle cycles -> boot_error=1.
//     Idle for 3*TIMEOUT_CYCLES before the first byte -> no error.
//  5. Back-to-back bytes (rx_valid held high) for N=4 -> one write every 4 cycles,
//     addresses 0..3 in order.
//  6. Reset asserted during S_DATA after word 1 -> all outputs return to reset values.
//     A fresh image with N=1 then loads word 0 and releases the core.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// ----------------------------------------------------------------------------
// boot_pkg
// Shared types and constants for the instruction-memory boot loader.
//   boot_state_e           : loader FSM states
//   BOOT_MAGIC             : required first word of every boot image
//   DEFAULT_TIMEOUT_CYCLES : idle-cycle limit between bytes once loading starts
//   is_loading()           : true for the states that accept image bytes
// ----------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        S_MAGIC,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } boot_state_e;

    localparam logic [31:0] BOOT_MAGIC             = 32'hB007_C0DE;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100000;

    function automatic logic is_loading(input boot_state_e s);
        return (s == S_MAGIC) || (s == S_LEN) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// ----------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles the loader's byte-stream input and its imem write port.
//   rx_valid/rx_data/rx_ready : valid/ready byte stream into the loader
//   imem_we/imem_addr/imem_wdata : one-cycle word write strobe into imem
// Modports:
//   master : environment side (byte source, imem sink)
//   slave  : loader side
// ----------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// ----------------------------------------------------------------------------
// byte_word_packer
// Packs accepted bytes into little-endian 32-bit words.
//   clk        in   system clock
//   clear      in   synchronous clear of the partial word and byte counter
//   byte_valid in   a byte is accepted this cycle
//   byte_data  in   the accepted byte
//   word       out  completed word (valid only while word_valid is high)
//   word_valid out  one-cycle pulse in the cycle the 4th byte is accepted
// The completed word is presented combinationally in the cycle of the 4th
// byte so the consumer can register its write on that same clock edge.
// ----------------------------------------------------------------------------
module byte_word_packer (
    input  logic        clk,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0]  byte_cnt;
    logic [23:0] partial;

    always_ff @(posedge clk) begin
        if (clear) begin
            byte_cnt <= '0;
            partial  <= '0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    partial[7:0]   <= byte_data;
                2'd1:    partial[15:8]  <= byte_data;
                2'd2:    partial[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    assign word       = {byte_data, partial};
    assign word_valid = byte_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// ----------------------------------------------------------------------------
// imem_boot_loader
// Boot sequencer for the rv32i core. Receives an image as a byte stream,
// checks the magic word, reads the word count N, writes N words into imem,
// then releases the core from reset.
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   bus          slave modport: rx_valid/rx_data/rx_ready byte stream,
//                imem_we/imem_addr/imem_wdata imem write port
//   core_reset_n out  active-low core reset; 0 until the image is loaded
//   boot_done    out  image loaded, core released
//   boot_error   out  bad magic, oversize length or timeout; sticky
// Image format: MAGIC, N, then N data words, all little-endian.
// ----------------------------------------------------------------------------
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH     = 1024,
    parameter int unsigned ADDR_W         = $clog2(IMEM_DEPTH),
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] MAGIC          = BOOT_MAGIC
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_boot_loader_if.slave    bus,
    output logic                 core_reset_n,
    output logic                 boot_done,
    output logic                 boot_error
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    boot_state_e     state;
    boot_state_e     state_next;

    logic            accept;
    logic            word_valid;
    logic [31:0]     word;
    logic            packer_clear;

    // Index is one bit wider than the address so N == IMEM_DEPTH fits.
    logic [ADDR_W:0] index;
    logic [ADDR_W:0] n_words;

    logic [TO_W-1:0] idle_cnt;
    logic            started;
    logic            running;
    logic            timeout_hit;

    logic            load_len;
    logic            data_write;

    assign accept       = bus.rx_valid && bus.rx_ready;
    assign packer_clear = reset || !is_loading(state);

    byte_word_packer u_packer (
        .clk        (clk),
        .clear      (packer_clear),
        .byte_valid (accept),
        .byte_data  (bus.rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // The idle timer stays parked until the first byte of an image arrives,
    // so a host may wait arbitrarily long before starting a download.
    assign running     = is_loading(state) && ((state != S_MAGIC) || started);
    assign timeout_hit = running && (idle_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) state <= S_MAGIC;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_len   = 1'b0;
        data_write = 1'b0;
        if (timeout_hit) begin
            state_next = S_ERR;
        end else begin
            case (state)
                S_MAGIC: begin
                    if (word_valid) state_next = (word == MAGIC) ? S_LEN : S_ERR;
                end
                S_LEN: begin
                    if (word_valid) begin
                        if (word == 32'd0) begin
                            state_next = S_DONE;
                        end else if (word > 32'(IMEM_DEPTH)) begin
                            state_next = S_ERR;
                        end else begin
                            load_len   = 1'b1;
                            state_next = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_valid) begin
                        data_write = 1'b1;
                        if (index == n_words - 1'b1) state_next = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index          <= '0;
            n_words        <= '0;
            idle_cnt       <= '0;
            started        <= 1'b0;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_reset_n   <= 1'b0;
            boot_done      <= 1'b0;
            boot_error     <= 1'b0;
        end else begin
            bus.rx_ready <= is_loading(state_next);

            if (accept) started <= 1'b1;

            if (accept || !running) idle_cnt <= '0;
            else                    idle_cnt <= idle_cnt + 1'b1;

            bus.imem_we <= data_write;
            if (data_write) begin
                bus.imem_addr  <= index[ADDR_W-1:0];
                bus.imem_wdata <= word;
                index          <= index + 1'b1;
            end

            if (load_len) begin
                n_words <= word[ADDR_W:0];
                index   <= '0;
            end

            // Registered from the current state: the core is released one
            // cycle after S_DONE, i.e. after the final imem write has landed.
            core_reset_n <= (state == S_DONE);
            boot_done    <= (state == S_DONE);
            boot_error   <= (state == S_ERR);
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed self-checking bench for imem_boot_loader.
// ----------------------------------------------------------------------------
module tb_imem_boot_loader;
    import boot_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;
    localparam int unsigned TO    = 20;

    logic clk = 1'b0;
    logic reset;
    logic core_reset_n;
    logic boot_done;
    logic boot_error;

    imem_boot_loader_if #(.ADDR_W(AW)) bus ();

    imem_boot_loader #(
        .IMEM_DEPTH     (DEPTH),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO),
        .MAGIC          (BOOT_MAGIC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .core_reset_n (core_reset_n),
        .boot_done    (boot_done),
        .boot_error   (boot_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write / release monitor, sampled on the falling edge.
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int            wr_cyc[$];
    logic          wr_core_n[$];
    int            done_cyc = -1;
    logic          done_q   = 1'b0;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            wr_cyc.push_back(cyc);
            wr_core_n.push_back(core_reset_n);
        end
        if (boot_done === 1'b1 && !done_q) done_cyc = cyc;
        done_q = (boot_done === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    task automatic idle();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"},   32'(bus.rx_ready),   32'd0);
        check({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
        check({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
        check({tag, "_core_rst_n"}, 32'(core_reset_n),   32'd0);
        check({tag, "_boot_done"},  32'(boot_done),      32'd0);
        check({tag, "_boot_error"}, 32'(boot_error),     32'd0);
    endtask

    int base;

    task automatic do_reset();
        idle();
        reset = 1'b1;
        settle(2);
        reset = 1'b0;
        settle(1);
        base = wr_addr.size();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        settle(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        settle(1);
        check("rst_release_ready", 32'(bus.rx_ready), 32'd1);
        base = wr_addr.size();

        // 1: two-word image
        send_word(32'hB007_C0DE);
        send_word(32'd2);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        idle();
        settle(3);
        check("t1_nwr",       32'(wr_addr.size() - base), 32'd2);
        check("t1_addr0",     32'(wr_addr[base]),         32'd0);
        check("t1_data0",     wr_data[base],              32'h0000_0013);
        check("t1_addr1",     32'(wr_addr[base+1]),       32'd1);
        check("t1_data1",     wr_data[base+1],            32'h0010_0093);
        check("t1_held",      32'(wr_core_n[base+1]),     32'd0);
        check("t1_done_lag",  32'(done_cyc - wr_cyc[base+1]), 32'd1);
        check("t1_boot_done", 32'(boot_done),             32'd1);
        check("t1_core_rn",   32'(core_reset_n),          32'd1);
        check("t1_ready",     32'(bus.rx_ready),          32'd0);
        check("t1_err",       32'(boot_error),            32'd0);

        // 2: bad magic
        do_reset();
        send_word(32'hDEAD_BEEF);
        idle();
        settle(3);
        check("t2_err",     32'(boot_error),            32'd1);
        check("t2_core_rn", 32'(core_reset_n),          32'd0);
        check("t2_ready",   32'(bus.rx_ready),          32'd0);
        check("t2_nwr",     32'(wr_addr.size() - base), 32'd0);

        // 3a: oversize length
        do_reset();
        send_word(32'hB007_C0DE);
        send_word(32'h0000_0401);
        idle();
        settle(3);
        check("t3a_err",  32'(boot_error),            32'd1);
        check("t3a_done", 32'(boot_done),             32'd0);
        check("t3a_nwr",  32'(wr_addr.size() - base), 32'd0);

        // 3b: empty image
        do_reset();
        send_word(32'hB007_C0DE);
        send_word(32'd0);
        idle();
        settle(3);
        check("t3b_done",    32'(boot_done),             32'd1);
        check("t3b_core_rn", 32'(core_reset_n),          32'd1);
        check("t3b_err",     32'(boot_error),            32'd0);
        check("t3b_nwr",     32'(wr_addr.size() - base), 32'd0);

        // 4a: stall mid-word
        do_reset();
        send_word(32'hB007_C0DE);
        send_word(32'd1);
        send(8'h13);
        send(8'h00);
        idle();
        settle(TO - 1);
        check("t4a_no_err_yet", 32'(boot_error), 32'd0);
        settle(4);
        check("t4a_err",     32'(boot_error),            32'd1);
        check("t4a_core_rn", 32'(core_reset_n),          32'd0);
        check("t4a_nwr",     32'(wr_addr.size() - base), 32'd0);

        // 4b: long idle before the first byte is not an error
        do_reset();
        settle(3 * TO);
        check("t4b_err",   32'(boot_error),   32'd0);
        check("t4b_ready", 32'(bus.rx_ready), 32'd1);
        send_word(32'hB007_C0DE);
        send_word(32'd1);
        send_word(32'hCAFE_F00D);
        idle();
        settle(3);
        check("t4b_done", 32'(boot_done),     32'd1);
        check("t4b_data", wr_data[base],      32'hCAFE_F00D);

        // 5: back-to-back stream, N=4, data bytes 00..0F
        do_reset();
        send_word(32'hB007_C0DE);
        send_word(32'd4);
        for (int i = 0; i < 16; i++) send(8'(i));
        idle();
        settle(3);
        check("t5_nwr", 32'(wr_addr.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_addr%0d", i), 32'(wr_addr[base+i]), 32'(i));
            check($sformatf("t5_data%0d", i), wr_data[base+i],
                  {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
            if (i > 0)
                check($sformatf("t5_gap%0d", i),
                      32'(wr_cyc[base+i] - wr_cyc[base+i-1]), 32'd4);
        end
        check("t5_done", 32'(boot_done), 32'd1);

        // 6: reset during S_DATA after word 1, then a fresh one-word image
        do_reset();
        send_word(32'hB007_C0DE);
        send_word(32'd3);
        send_word(32'h4433_2211);
        send_word(32'h8877_6655);
        send(8'hE0);
        send(8'hE1);
        idle();
        reset = 1'b1;
        settle(2);
        check_reset_outputs("t6_rst");
        reset = 1'b0;
        settle(1);
        base = wr_addr.size();
        send_word(32'hB007_C0DE);
        send_word(32'd1);
        send_word(32'hDDCC_BBAA);
        idle();
        settle(3);
        check("t6_nwr",     32'(wr_addr.size() - base), 32'd1);
        check("t6_addr",    32'(wr_addr[base]),         32'd0);
        check("t6_data",    wr_data[base],              32'hDDCC_BBAA);
        check("t6_done",    32'(boot_done),             32'd1);
        check("t6_core_rn", 32'(core_reset_n),          32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
